// File: rtl/jt12_slot_sched.sv
// Slot counter with op/ch decode for the 24-slot operator rings, plus a two-requester
// write scheduler that holds each accepted write until its slot reaches the ring input.
module jt12_slot_sched #(
    parameter int W      = 7,
    parameter int SLOTS  = 24,
    parameter int OFFSET = 0,
    parameter int RR     = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         req0,
    input  logic [2:0]   ch0,
    input  logic [1:0]   op0,
    input  logic [W-1:0] din0,
    output logic         ack0,
    input  logic         req1,
    input  logic [2:0]   ch1,
    input  logic [1:0]   op1,
    input  logic [W-1:0] din1,
    output logic         ack1,
    output logic [4:0]   cnt,
    output logic [1:0]   cur_op,
    output logic [2:0]   cur_ch,
    output logic         zero,
    output logic         busy,
    output logic         inj_en,
    output logic [W-1:0] inj_data
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t       state;
    logic [4:0]   tgt;
    logic         ptr;
    logic         pick1;
    logic         can_grant;
    logic [2:0]   sel_ch;
    logic [1:0]   sel_op;
    logic [W-1:0] sel_din;
    logic [4:0]   quo;
    logic [4:0]   rem;

    // Sum can exceed SLOTS (op*6+ch plus offset), so reduce it in a wider domain.
    function automatic logic [4:0] slot_of(input logic [1:0] op, input logic [2:0] ch);
        logic [6:0] sum;
        sum = 7'(op) * 7'd6 + 7'(ch) + 7'(OFFSET);
        return 5'(sum % 7'(SLOTS));
    endfunction

    assign quo    = cnt / 5'd6;
    assign rem    = cnt % 5'd6;
    assign cur_op = quo[1:0];
    assign cur_ch = rem[2:0];
    assign zero   = (cnt == 5'd0);
    assign busy   = (state == WAIT);
    assign inj_en = (state == WAIT) && (cnt == tgt);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 5'd0;
        else if (clk_en)
            cnt <= (cnt == 5'(SLOTS - 1)) ? 5'd0 : cnt + 5'd1;
    end

    // The ack cycle blocks a new grant so a requester still holding req there is not served twice.
    always_comb begin
        pick1 = 1'b0;
        if (req1 && !req0)
            pick1 = 1'b1;
        else if (req0 && req1 && (RR != 0) && ptr)
            pick1 = 1'b1;
        can_grant = (state == IDLE) && !ack0 && !ack1 && (req0 || req1);
        sel_ch    = pick1 ? ch1  : ch0;
        sel_op    = pick1 ? op1  : op0;
        sel_din   = pick1 ? din1 : din0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            ptr      <= 1'b0;
            inj_data <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_grant) begin
                        ack0 <= !pick1;
                        ack1 <= pick1;
                        if (RR != 0)
                            ptr <= !pick1;
                        if (sel_ch <= 3'd5) begin
                            inj_data <= sel_din;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (clk_en && inj_en)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && can_grant)
            tgt <= slot_of(sel_op, sel_ch);
    end

endmodule

// File: tb/tb_jt12_slot_sched.sv
// Directed bench for jt12_slot_sched: counter/decode, injection timing, arbitration
// (fixed priority on one instance, round-robin on another), clk_en stall, invalid target, reset.
module tb_jt12_slot_sched;

    logic       clk = 1'b0;
    logic       rst, clk_en;
    logic       req0, req1;
    logic [2:0] ch0, ch1;
    logic [1:0] op0, op1;
    logic [6:0] din0, din1;

    logic       ack0, ack1, zero, busy, inj_en;
    logic [4:0] cnt;
    logic [1:0] cur_op;
    logic [2:0] cur_ch;
    logic [6:0] inj_data;

    logic       ack0_r, ack1_r, zero_r, busy_r, inj_en_r;
    logic [4:0] cnt_r;
    logic [1:0] cur_op_r;
    logic [2:0] cur_ch_r;
    logic [6:0] inj_data_r;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jt12_slot_sched #(.W(7), .SLOTS(24), .OFFSET(0), .RR(0)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req0(req0), .ch0(ch0), .op0(op0), .din0(din0), .ack0(ack0),
        .req1(req1), .ch1(ch1), .op1(op1), .din1(din1), .ack1(ack1),
        .cnt(cnt), .cur_op(cur_op), .cur_ch(cur_ch), .zero(zero),
        .busy(busy), .inj_en(inj_en), .inj_data(inj_data)
    );

    jt12_slot_sched #(.W(7), .SLOTS(24), .OFFSET(0), .RR(1)) dut_rr (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req0(req0), .ch0(ch0), .op0(op0), .din0(din0), .ack0(ack0_r),
        .req1(req1), .ch1(ch1), .op1(op1), .din1(din1), .ack1(ack1_r),
        .cnt(cnt_r), .cur_op(cur_op_r), .cur_ch(cur_ch_r), .zero(zero_r),
        .busy(busy_r), .inj_en(inj_en_r), .inj_data(inj_data_r)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_en = 1'b0;
        req0 = 1'b0; ch0 = 3'd0; op0 = 2'd0; din0 = 7'd0;
        req1 = 1'b0; ch1 = 3'd0; op1 = 2'd0; din1 = 7'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Runs the ring until the pending write lands; expects exactly one injection at tgt.
    task automatic wait_inj(input logic [4:0] tgt, input logic [6:0] data);
        int ninj = 0;
        for (int i = 0; i < 60; i++) begin
            if (inj_en) begin
                ninj++;
                chk("inj_slot", 32'(cnt), 32'(tgt));
                chk("inj_data", 32'(inj_data), 32'(data));
            end
            if (!busy) break;
            step();
        end
        chk("inj_count", ninj, 1);
        chk("busy_after_inj", 32'(busy), 0);
    endtask

    initial begin
        int ninj, g, lost;
        logic got1;

        // Reset state and counter/decode sweep
        do_reset();
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'({ack0, ack1}), 0);
        chk("rst_inj_en", 32'(inj_en), 0);
        chk("rst_inj_data", 32'(inj_data), 0);
        chk("rst_zero", 32'(zero), 1);
        for (int i = 1; i <= 50; i++) begin
            clk_en = 1'b1;
            step();
            chk("cnt_run", 32'(cnt), 32'(i % 24));
            chk("zero_run", 32'(zero), 32'((i % 24) == 0));
            chk("op_run", 32'(cur_op), 32'((i % 24) / 6));
            chk("ch_run", 32'(cur_ch), 32'((i % 24) % 6));
            if ((i % 24) == 13) begin
                chk("op_13", 32'(cur_op), 2);
                chk("ch_13", 32'(cur_ch), 1);
            end
        end
        chk("cnt_after_50", 32'(cnt), 2);
        clk_en = 1'b1;
        step();
        chk("cnt_3", 32'(cnt), 3);

        // Single write: ch2 op1 -> slot 8
        req0 = 1'b1; ch0 = 3'd2; op0 = 2'd1; din0 = 7'h55;
        step();
        chk("ack0_single", 32'(ack0), 1);
        chk("busy_single", 32'(busy), 1);
        req0 = 1'b0;
        step();
        chk("ack0_pulse", 32'(ack0), 0);
        wait_inj(5'd8, 7'h55);

        // Fixed priority: req0 first, req1 only after req0's injection
        req0 = 1'b1; ch0 = 3'd0; op0 = 2'd0; din0 = 7'h11;
        req1 = 1'b1; ch1 = 3'd5; op1 = 2'd3; din1 = 7'h22;
        step();
        chk("prio_ack0", 32'(ack0), 1);
        chk("prio_ack1", 32'(ack1), 0);
        req0 = 1'b0;
        ninj = 0; got1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ack1) begin
                chk("ack1_after_inj0", ninj, 1);
                got1 = 1'b1;
                req1 = 1'b0;
            end
            if (inj_en) begin
                ninj++;
                if (ninj == 1) begin
                    chk("prio_slot0", 32'(cnt), 0);
                    chk("prio_data0", 32'(inj_data), 32'h11);
                end else begin
                    chk("prio_slot1", 32'(cnt), 23);
                    chk("prio_data1", 32'(inj_data), 32'h22);
                end
            end
            if (ninj == 2 && !busy) break;
            step();
        end
        chk("prio_inj_count", ninj, 2);
        chk("prio_got_ack1", 32'(got1), 1);

        // Round-robin with both requests held
        do_reset();
        clk_en = 1'b1;
        req0 = 1'b1; ch0 = 3'd1; op0 = 2'd0; din0 = 7'h01;
        req1 = 1'b1; ch1 = 3'd2; op1 = 2'd0; din1 = 7'h02;
        g = 0;
        for (int i = 0; i < 300 && g < 4; i++) begin
            step();
            if (ack0_r || ack1_r) begin
                chk("rr_grant", 32'({ack1_r, ack0_r}), (g % 2 == 0) ? 32'd1 : 32'd2);
                g++;
            end
        end
        chk("rr_grants", g, 4);
        req0 = 1'b0; req1 = 1'b0;

        // clk_en stall during WAIT
        do_reset();
        req0 = 1'b1; ch0 = 3'd3; op0 = 2'd0; din0 = 7'h33;
        step();
        chk("stall_ack", 32'(ack0), 1);
        chk("stall_cnt0", 32'(cnt), 0);
        req0 = 1'b0;
        clk_en = 1'b1;
        step(); step(); step();
        chk("stall_inj_on", 32'(inj_en), 1);
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_cnt", 32'(cnt), 3);
            chk("stall_inj", 32'(inj_en), 1);
        end
        clk_en = 1'b1;
        step();
        chk("stall_cnt_adv", 32'(cnt), 4);
        chk("stall_inj_off", 32'(inj_en), 0);
        chk("stall_busy_off", 32'(busy), 0);

        // Write whose target equals the current slot injects immediately
        clk_en = 1'b0;
        req0 = 1'b1; ch0 = 3'd4; op0 = 2'd0; din0 = 7'h44;
        step();
        req0 = 1'b0;
        chk("same_slot_inj", 32'(inj_en), 1);
        chk("same_slot_data", 32'(inj_data), 32'h44);
        clk_en = 1'b1;
        step();
        chk("same_slot_done", 32'(busy), 0);

        // Invalid channel: acked, dropped
        req0 = 1'b1; ch0 = 3'd6; op0 = 2'd1; din0 = 7'h66;
        step();
        chk("inv_ack", 32'(ack0), 1);
        chk("inv_busy", 32'(busy), 0);
        req0 = 1'b0;
        lost = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (inj_en || busy) lost++;
        end
        chk("inv_no_inj", lost, 0);

        // Reset while waiting for slot 20
        do_reset();
        clk_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("mid_cnt5", 32'(cnt), 5);
        clk_en = 1'b0;
        req0 = 1'b1; ch0 = 3'd2; op0 = 2'd3; din0 = 7'h7F;
        step();
        chk("mid_ack", 32'(ack0), 1);
        chk("mid_busy", 32'(busy), 1);
        req0 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_cnt_rst", 32'(cnt), 0);
        chk("mid_busy_rst", 32'(busy), 0);
        chk("mid_inj_rst", 32'(inj_en), 0);
        clk_en = 1'b1;
        lost = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (inj_en) lost++;
        end
        chk("mid_no_inj", lost, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
